pic_drain: RTL and testbench
============================

// Module: pic_drain
// PURPOSE
//  Read-side consumer of the parallel indices comparison unit's match FIFO.
//  Pops matched index pairs whenever the FIFO is non-empty and room exists.
//  Buffers the in-flight pops in a small skid queue and presents each pair to
//  the FPU MAC stage over a valid/ready handshake.
//  Counts matches per row and reports row completion once the row is fully drained.
// PARAMETERS
//  RD_LAT      1   FIFO read latency: cycles from read=1 to fifo_data valid (1..2)
//  SKID_DEPTH  4   skid queue entries; must be >= RD_LAT+2
//  CNT_W       16  width of per-row match counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-high reset
//  fifo_empty    in   1      match FIFO holds no entries (same-cycle status)
//  fifo_data     in   32     popped entry: [31:16]=A index, [15:0]=B index
//  read          out  1      pop strobe to match FIFO, one entry per cycle
//  row_done      in   1      1-cycle pulse: producer has written last compare of row
//  mac_valid     out  1      mac_a_idx/mac_b_idx hold a valid pair
//  mac_ready     in   1      MAC accepts pair this cycle
//  mac_a_idx     out  16     A index of head pair
//  mac_b_idx     out  16     B index of head pair
//  row_complete  out  1      1-cycle pulse: row fully drained and delivered
//  match_count   out  CNT_W  matches in completed row; valid while row_complete=1
//  row_overrun   out  1      sticky: row_done arrived while previous row still flushing
// BEHAVIOUR
//  Reset: all outputs 0. Skid queue, in-flight counter, match counter and FSM
//   cleared (FSM -> IDLE). Reset mid-row discards any in-flight or queued pairs.
//  Pop issue: read=1 iff !fifo_empty && state!=COMPLETE && (skid_cnt+inflight)<SKID_DEPTH.
//   read is never asserted while fifo_empty=1.
//  Capture: a read issued in cycle t writes fifo_data into the skid tail at the end of
//   cycle t+RD_LAT. inflight = reads issued but not yet captured (0..RD_LAT).
//  Output: mac_valid = skid non-empty. mac_a_idx/mac_b_idx = head entry, held stable
//   while mac_valid && !mac_ready. A beat transfers on mac_valid && mac_ready.
//   Same-cycle capture and transfer keep skid_cnt unchanged. Order is strictly FIFO.
//   With RD_LAT=1 and mac_ready=1, first mac_valid is one cycle after read.
//   Sustained throughput is 1 pair/cycle.
//  Counter: match counter increments on each transferred beat and saturates at
//   2^CNT_W-1. It is cleared in the COMPLETE cycle.
//  FSM:
//   IDLE     -> FLUSH on row_done.
//   FLUSH    -> COMPLETE when fifo_empty && inflight==0 && skid empty.
//               A beat transferring in the same cycle still counts toward this row.
//   COMPLETE -> IDLE unconditionally. row_complete=1 and match_count=counter for
//               exactly this one cycle. Pops are blocked during COMPLETE.
//  row_done in FLUSH or COMPLETE: sets row_overrun and is otherwise ignored.
//   row_overrun is cleared only by rst.
//  Row with zero matches: row_done in IDLE with empty path gives FLUSH for 1 cycle,
//   then COMPLETE with match_count=0.
//  match_count is 0 whenever row_complete=0.
// TESTING
//  Reset: assert rst mid-idle -> read, mac_valid, row_complete, match_count and
//   row_overrun all 0 on the same cycle, with no clock edge required.
//  Single pair: fifo_data=0x0003_0007, fifo_empty low 1 cycle, mac_ready=1.
//   -> read=1 at t, mac_valid=1 at t+1 with a=3, b=7, then mac_valid=0.
//  Backpressure: 6 entries queued, mac_ready=0 for 8 cycles then 1.
//   -> exactly 4 reads issued before stall; 6 pairs delivered in order; none lost/duplicated.
//  Row count: 3 pairs, then row_done.
//   -> row_complete pulses once, match_count=3, exactly one cycle after last transfer.
//  Empty row: row_done with empty FIFO and skid.
//   -> row_complete two cycles later with match_count=0.
//  Overrun and mid-row reset: row_done twice 1 cycle apart -> row_overrun=1.
//   Then rst with 2 pairs in skid -> mac_valid=0; after release no stale pair appears.

Source files
------------

// File: rtl/pic_drain.sv
// -----------------------------------------------------------------------------
// pic_drain
// Read-side consumer of the parallel indices comparison unit's match FIFO.
// Pops matched (A,B) index pairs while the FIFO is non-empty and the skid
// queue has room, buffers them, and hands them to the FPU MAC stage over a
// valid/ready handshake. Counts delivered pairs per row and pulses
// row_complete once a row announced by row_done has fully drained.
//
// Parameters
//   RD_LAT      FIFO read latency in cycles (1..2)
//   SKID_DEPTH  skid queue entries (>= RD_LAT+2)
//   CNT_W       width of the per-row match counter
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   fifo_empty    match FIFO has no entries (same-cycle status)
//   fifo_data     popped entry, [31:16]=A index, [15:0]=B index
//   read          pop strobe to the match FIFO
//   row_done      producer finished the current row (1-cycle pulse)
//   mac_valid     mac_a_idx/mac_b_idx carry a valid pair
//   mac_ready     MAC accepts the pair this cycle
//   mac_a_idx     A index of the head pair
//   mac_b_idx     B index of the head pair
//   row_complete  row fully drained and delivered (1-cycle pulse)
//   match_count   pairs delivered in the completed row, 0 otherwise
//   row_overrun   sticky: row_done arrived while a row was still finishing
// -----------------------------------------------------------------------------
module pic_drain #(
   parameter int RD_LAT     = 1,
   parameter int SKID_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [31:0]      fifo_data,
   output logic             read,
   input  logic             row_done,
   output logic             mac_valid,
   input  logic             mac_ready,
   output logic [15:0]      mac_a_idx,
   output logic [15:0]      mac_b_idx,
   output logic             row_complete,
   output logic [CNT_W-1:0] match_count,
   output logic             row_overrun
);

   localparam int PTR_W    = $clog2(SKID_DEPTH);
   localparam int SKCNT_W  = $clog2(SKID_DEPTH + 1);
   localparam int OCC_W    = $clog2(SKID_DEPTH + RD_LAT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [RD_LAT-1:0]    rd_pipe_q, rd_pipe_d;
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [SKCNT_W-1:0]   skid_cnt_q, skid_cnt_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 overrun_q, overrun_d;
   logic [31:0]          skid_mem_q [SKID_DEPTH];

   logic [OCC_W-1:0]     inflight;
   logic [OCC_W-1:0]     occ;
   logic                 capture;
   logic                 skid_empty;
   logic                 xfer;
   logic                 push;
   logic                 pop;
   logic                 drained;
   logic [31:0]          head_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // rd_pipe_q[i] marks a read issued i+1 cycles ago; the oldest bit lines up
   // with the cycle in which its data is present on fifo_data.
   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + OCC_W'(rd_pipe_q[i]);
      end
   end

   assign capture    = rd_pipe_q[RD_LAT-1];
   assign skid_empty = (skid_cnt_q == '0);
   assign occ        = OCC_W'(skid_cnt_q) + inflight;

   // rst gates read combinationally so the strobe drops the moment reset is
   // applied, without waiting for a clock edge.
   assign read = !rst && !fifo_empty && (state_q != COMPLETE) &&
                 (occ < OCC_W'(SKID_DEPTH));

   // The entry arriving this cycle is treated as already sitting at the skid
   // tail: with an empty queue it is presented straight from fifo_data, which
   // gives a one-cycle read-to-valid path and 1 pair/cycle throughput.
   assign mac_valid = !skid_empty || capture;
   assign head_data = skid_empty ? fifo_data : skid_mem_q[head_q];
   assign mac_a_idx = mac_valid ? head_data[31:16] : 16'h0;
   assign mac_b_idx = mac_valid ? head_data[15:0]  : 16'h0;
   assign xfer      = mac_valid && mac_ready;

   // A bypassed beat never occupies storage; everything else is written.
   assign push = capture && !(skid_empty && mac_ready);
   assign pop  = xfer && !skid_empty;

   always_comb begin
      rd_pipe_d  = RD_LAT'({rd_pipe_q, read});
      head_d     = pop  ? ptr_inc(head_q) : head_q;
      tail_d     = push ? ptr_inc(tail_q) : tail_q;
      skid_cnt_d = skid_cnt_q;
      if (push && !pop) begin
         skid_cnt_d = skid_cnt_q + SKCNT_W'(1);
      end else if (pop && !push) begin
         skid_cnt_d = skid_cnt_q - SKCNT_W'(1);
      end
   end

   // Judged on next-cycle occupancy so that a beat leaving this cycle (from
   // the queue or via bypass) still lands in the row that is closing.
   assign drained = fifo_empty && (rd_pipe_d == '0) && (skid_cnt_d == '0);

   always_comb begin
      state_d   = state_q;
      overrun_d = overrun_q;
      cnt_d     = cnt_q;
      if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (row_done) state_d = FLUSH;
         end
         FLUSH: begin
            if (row_done) overrun_d = 1'b1;
            if (drained)  state_d   = COMPLETE;
         end
         COMPLETE: begin
            if (row_done) overrun_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign row_complete = (state_q == COMPLETE);
   assign match_count  = row_complete ? cnt_q : '0;
   assign row_overrun  = overrun_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_pipe_q  <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         skid_cnt_q <= '0;
         cnt_q      <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_pipe_q  <= rd_pipe_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         skid_cnt_q <= skid_cnt_d;
         cnt_q      <= cnt_d;
         overrun_q  <= overrun_d;
      end
   end

   // NOTE: the skid storage is deliberately not reset; skid_cnt_q decides
   // which entries are live, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (push) skid_mem_q[tail_q] <= fifo_data;
   end

endmodule

// File: tb/tb_pic_drain.sv
// -----------------------------------------------------------------------------
// tb_pic_drain
// Self-checking bench for pic_drain. The bench plays the match FIFO (a queue
// with one cycle of read latency) and keeps a scoreboard: every pair loaded
// into the FIFO is expected at the MAC port in load order, and every row_done
// expects one row_complete carrying the saturated number of pairs loaded for
// that row. A monitor on the falling edge pops and compares. A narrow counter
// (CNT_W=4) is used so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pic_drain;

   localparam int RD_LAT     = 1;
   localparam int SKID_DEPTH = 4;
   localparam int CNT_W      = 4;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             fifo_empty;
   logic [31:0]      fifo_data;
   logic             read;
   logic             row_done;
   logic             mac_valid;
   logic             mac_ready;
   logic [15:0]      mac_a_idx;
   logic [15:0]      mac_b_idx;
   logic             row_complete;
   logic [CNT_W-1:0] match_count;
   logic             row_overrun;

   pic_drain #(
      .RD_LAT     (RD_LAT),
      .SKID_DEPTH (SKID_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .read         (read),
      .row_done     (row_done),
      .mac_valid    (mac_valid),
      .mac_ready    (mac_ready),
      .mac_a_idx    (mac_a_idx),
      .mac_b_idx    (mac_b_idx),
      .row_complete (row_complete),
      .match_count  (match_count),
      .row_overrun  (row_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int rd_cyc;
   } row_exp_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] fifo_q[$];
   logic [31:0] exp_q[$];
   row_exp_t    row_q[$];
   int          row_load_cnt = 0;
   bit          row_pending = 0;
   bit          exp_overrun = 0;
   bit          rand_ready = 0;
   int          rd_count = 0;
   bit          rd_s;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // One clock: sample the pop strobe mid-cycle, then after the edge let the
   // FIFO model present the popped entry (one cycle of read latency).
   task automatic tick();
      @(negedge clk);
      rd_s = read;
      if (read) rd_count++;
      @(posedge clk);
      #1;
      if (rd_s && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      row_done   = 1'b0;
      if (rand_ready) mac_ready = ($urandom_range(0, 9) < 7);
   endtask

   task automatic load(input logic [31:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
      row_load_cnt++;
      fifo_empty = 1'b0;
   endtask

   task automatic issue_row_done();
      row_exp_t r;
      row_done = 1'b1;
      if (row_pending) begin
         exp_overrun = 1'b1;
      end else begin
         r.cnt    = (row_load_cnt > CNT_MAX) ? CNT_MAX : row_load_cnt;
         r.rd_cyc = cyc;
         row_q.push_back(r);
         row_load_cnt = 0;
         row_pending  = 1'b1;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || row_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check(name, exp_q.size() + row_q.size(), 0);
   endtask

   // Monitor: scoreboard pops, handshake stability, row completion timing.
   int          last_beat_cyc = -100;
   bit          prev_stall = 0;
   logic [15:0] prev_a, prev_b;
   bit          ovr_prev = 0;

   always @(negedge clk) begin
      logic [31:0] e;
      row_exp_t    r;
      int          exp_c;
      if (rst) begin
         prev_stall = 0;
         ovr_prev   = 0;
      end else begin
         if (read) check("read_while_empty", fifo_empty, 1'b0);
         if (prev_stall) begin
            check("hold_under_backpressure", {mac_valid, mac_a_idx, mac_b_idx},
                  {1'b1, prev_a, prev_b});
         end
         if (mac_valid && mac_ready) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_beat: got a=0x%0h b=0x%0h expected no beat at t=%0t",
                        mac_a_idx, mac_b_idx, $time);
            end else begin
               e = exp_q.pop_front();
               check("beat_pair", {mac_a_idx, mac_b_idx}, e);
            end
            last_beat_cyc = cyc;
         end
         prev_stall = mac_valid && !mac_ready;
         prev_a     = mac_a_idx;
         prev_b     = mac_b_idx;
         if (row_complete) begin
            if (row_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL spurious_row_complete: got pulse expected none at t=%0t", $time);
            end else begin
               r     = row_q.pop_front();
               exp_c = (last_beat_cyc + 1 > r.rd_cyc + 2) ? last_beat_cyc + 1 : r.rd_cyc + 2;
               check("match_count", match_count, r.cnt);
               check("complete_cycle", cyc, exp_c);
               row_pending = 1'b0;
            end
         end else begin
            check("match_count_idle_zero", match_count, 0);
         end
         check("row_overrun", row_overrun, ovr_prev);
         ovr_prev = exp_overrun;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      fifo_empty = 1'b0;
      fifo_data  = 32'h1234_5678;
      row_done   = 1'b0;
      mac_ready  = 1'b1;
      #2;
      // Reset state, before any clock edge, with the FIFO claiming data.
      check("rst_read", read, 1'b0);
      check("rst_mac_valid", mac_valid, 1'b0);
      check("rst_mac_a", mac_a_idx, 16'h0);
      check("rst_row_complete", row_complete, 1'b0);
      check("rst_match_count", match_count, 0);
      check("rst_row_overrun", row_overrun, 1'b0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      fifo_empty = 1'b1;
      tick();
      tick();

      // Row of three pairs.
      load(32'h0001_0002);
      load(32'h0003_0004);
      load(32'h0005_0006);
      tick();
      issue_row_done();
      tick();
      drain("row3_drain", 50);

      // Empty row.
      tick();
      issue_row_done();
      tick();
      drain("empty_row_drain", 20);

      // Single pair: read at t, valid at t+1, then gone.
      tick();
      load(32'h0003_0007);
      #3;
      check("single_read", read, 1'b1);
      tick();
      #3;
      check("single_valid", mac_valid, 1'b1);
      check("single_a", mac_a_idx, 16'h3);
      check("single_b", mac_b_idx, 16'h7);
      tick();
      #3;
      check("single_valid_drop", mac_valid, 1'b0);
      tick();

      // Backpressure: six queued, MAC stalled for eight cycles.
      mac_ready = 1'b0;
      rd_count  = 0;
      for (int i = 0; i < 6; i++) load({16'(16'h100 + i), 16'(16'h200 + i)});
      for (int i = 0; i < 8; i++) tick();
      check("bp_reads_before_stall", rd_count, 4);
      mac_ready = 1'b1;
      drain("bp_drain", 50);
      issue_row_done();
      tick();
      drain("bp_row_drain", 20);

      // Overrun: row_done on consecutive cycles.
      issue_row_done();
      tick();
      issue_row_done();
      tick();
      drain("overrun_drain", 20);
      #3;
      check("overrun_sticky", row_overrun, 1'b1);

      // Mid-row reset with two pairs parked in the skid queue.
      mac_ready = 1'b0;
      load(32'hAAAA_0001);
      load(32'hAAAA_0002);
      tick();
      tick();
      tick();
      #1;
      check("skid_loaded_valid", mac_valid, 1'b1);
      #1;
      rst          = 1'b1;
      exp_q        = fifo_q;
      row_q.delete();
      row_pending  = 1'b0;
      exp_overrun  = 1'b0;
      row_load_cnt = fifo_q.size();
      #1;
      check("midrst_mac_valid", mac_valid, 1'b0);
      check("midrst_read", read, 1'b0);
      check("midrst_row_overrun", row_overrun, 1'b0);
      check("midrst_row_complete", row_complete, 1'b0);
      check("midrst_match_count", match_count, 0);
      tick();
      rst       = 1'b0;
      mac_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("post_rst_no_stale", exp_q.size(), 0);

      // Randomized rows, random backpressure; the first row saturates.
      rand_ready = 1'b1;
      for (int row = 0; row < 12; row++) begin
         int n;
         n = (row == 0) ? 20 : $urandom_range(0, 20);
         for (int i = 0; i < n; i++) begin
            load($urandom());
            if ($urandom_range(0, 2) != 0) tick();
         end
         for (int i = $urandom_range(0, 3); i > 0; i--) tick();
         issue_row_done();
         tick();
         drain("rand_row_drain", 400);
      end
      rand_ready = 1'b0;
      mac_ready  = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
